// File: rtl/square_ctrl_pkg.sv
// Shared constants, register addresses and sweep arithmetic for the
// square-channel control slice.
package square_ctrl_pkg;

    typedef enum logic [2:0] {
        NRX1 = 3'd0,
        NRX2 = 3'd1,
        NRX3 = 3'd2,
        NRX4 = 3'd3,
        NRX0 = 3'd4
    } reg_addr_e;

    localparam logic [6:0] LEN_MAX     = 7'd64;
    localparam logic [3:0] ENV_MAX     = 4'd15;
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

    // Bit 11 of the result is the overflow flag (result > 2047).
    function automatic logic [11:0] sweep_calc(input logic [10:0] shadow,
                                               input logic [2:0]  shift,
                                               input logic        neg);
        logic [11:0] base;
        logic [11:0] delta;
        base  = {1'b0, shadow};
        delta = {1'b0, shadow >> shift};
        return neg ? (base - delta) : (base + delta);
    endfunction

endpackage

// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: clock divider plus 3-bit step counter; emits the
// per-step length/sweep/envelope tick pulses. Shareable across channels.
module apu_frame_sequencer
    import square_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 8192
) (
    input  logic       system_clock,
    input  logic       reset,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [2:0] seq_step
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divider;
    logic [2:0]       step_nxt;

    assign step_nxt = seq_step + 3'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            divider     <= '0;
            seq_step    <= 3'd0;
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
        end else if (divider == DIV_LAST) begin
            // Ticks belong to the step being entered and last one cycle.
            divider     <= '0;
            seq_step    <= step_nxt;
            length_tick <= LEN_STEPS[step_nxt];
            sweep_tick  <= SWEEP_STEPS[step_nxt];
            env_tick    <= ENV_STEPS[step_nxt];
        end else begin
            divider     <= divider + DIV_W'(1);
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/square_channel_ctrl.sv
// Control/sequencing for one square-wave channel: register file, length,
// envelope, trigger. Optional frequency sweep under SQUARE_CTRL_SWEEP_EN.
module square_channel_ctrl
    import square_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 8192
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [1:0]  duty,
    output logic [10:0] freq,
    output logic [3:0]  volume,
    output logic        channel_on,
    output logic        phase_reset,
    output logic [2:0]  seq_step
);

    logic        length_tick, sweep_tick, env_tick;
    logic        w_nrx1, w_nrx2, w_nrx3, w_nrx4, trig;
    logic        len_en, len_en_nxt, len_dec;
    logic [6:0]  len_cnt;
    logic [3:0]  env_init, env_timer;
    logic        env_dir, env_dir_nxt, dac_on;
    logic [2:0]  env_period, env_period_nxt;
    logic [10:0] freq_nxt;
    logic        sw_load, sw_kill, sw_trig_kill;
    logic [10:0] sw_freq;

    apu_frame_sequencer #(.CLK_DIV(CLK_DIV)) u_seq (
        .system_clock (system_clock),
        .reset        (reset),
        .length_tick  (length_tick),
        .sweep_tick   (sweep_tick),
        .env_tick     (env_tick),
        .seq_step     (seq_step)
    );

    // The *_nxt values are the register fields with this cycle's write
    // applied, so any tick in the same cycle sees the written value.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_nrx1         = wr_en && (wr_addr == NRX1);
        w_nrx2         = wr_en && (wr_addr == NRX2);
        w_nrx3         = wr_en && (wr_addr == NRX3);
        w_nrx4         = wr_en && (wr_addr == NRX4);
        trig           = w_nrx4 && wr_data[7];
        len_en_nxt     = w_nrx4 ? wr_data[6] : len_en;
        env_period_nxt = w_nrx2 ? wr_data[2:0] : env_period;
        env_dir_nxt    = w_nrx2 ? wr_data[3] : env_dir;
        dac_on         = (env_init != 4'd0) || env_dir;
        freq_nxt       = freq;
        if (w_nrx3) freq_nxt[7:0]  = wr_data;
        if (w_nrx4) freq_nxt[10:8] = wr_data[2:0];
        len_dec = length_tick && len_en_nxt && (len_cnt != 7'd0) && !trig && !w_nrx1;
    end

`ifdef SQUARE_CTRL_SWEEP_EN
    logic        w_nrx0, sw_neg, sw_fire;
    logic [2:0]  sw_period, sw_shift;
    logic [3:0]  sw_timer;
    logic [10:0] shadow;
    logic [11:0] trig_calc, sw_new, sw_recheck;

    always_comb begin
        w_nrx0       = wr_en && (wr_addr == NRX0);
        trig_calc    = sweep_calc(freq_nxt, sw_shift, sw_neg);
        sw_trig_kill = (sw_shift != 3'd0) && trig_calc[11];
        sw_fire      = sweep_tick && !trig && (sw_timer <= 4'd1) && (sw_period != 3'd0);
        sw_new       = sweep_calc(shadow, sw_shift, sw_neg);
        sw_recheck   = sweep_calc(sw_new[10:0], sw_shift, sw_neg);
        sw_load      = sw_fire && !sw_new[11] && (sw_shift != 3'd0);
        sw_kill      = sw_fire && (sw_new[11] || (sw_load && sw_recheck[11]));
        sw_freq      = sw_new[10:0];
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            sw_period <= 3'd0;
            sw_neg    <= 1'b0;
            sw_shift  <= 3'd0;
            sw_timer  <= 4'd0;
            shadow    <= 11'd0;
        end else begin
            if (w_nrx0) {sw_period, sw_neg, sw_shift} <= wr_data[6:0];
            if (trig) begin
                shadow   <= freq_nxt;
                sw_timer <= (sw_period == 3'd0) ? 4'd8 : {1'b0, sw_period};
            end else if (sweep_tick) begin
                if (sw_timer <= 4'd1)
                    sw_timer <= (sw_period == 3'd0) ? 4'd8 : {1'b0, sw_period};
                else
                    sw_timer <= sw_timer - 4'd1;
                if (sw_load) shadow <= sw_new[10:0];
            end
        end
    end
`else
    logic sweep_unused;
    assign sweep_unused = sweep_tick;
    assign sw_load      = 1'b0;
    assign sw_kill      = 1'b0;
    assign sw_trig_kill = 1'b0;
    assign sw_freq      = 11'd0;
`endif

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            duty        <= 2'd0;
            freq        <= 11'd0;
            volume      <= 4'd0;
            channel_on  <= 1'b0;
            phase_reset <= 1'b0;
            len_cnt     <= 7'd0;
            len_en      <= 1'b0;
            env_init    <= 4'd0;
            env_dir     <= 1'b0;
            env_period  <= 3'd0;
            env_timer   <= 4'd0;
        end else begin
            phase_reset <= trig;
            freq        <= sw_load ? sw_freq : freq_nxt;
            len_en      <= len_en_nxt;
            env_period  <= env_period_nxt;
            env_dir     <= env_dir_nxt;
            if (w_nrx1) begin
                duty    <= wr_data[7:6];
                len_cnt <= LEN_MAX - {1'b0, wr_data[5:0]};
            end
            if (w_nrx2) begin
                env_init <= wr_data[7:4];
                if (wr_data[7:3] == 5'd0) channel_on <= 1'b0;
            end
            if (trig) begin
                channel_on <= dac_on && !sw_trig_kill;
                if (len_cnt == 7'd0) len_cnt <= LEN_MAX;
                volume    <= env_init;
                env_timer <= (env_period == 3'd0) ? 4'd8 : {1'b0, env_period};
            end else begin
                if (len_dec) begin
                    len_cnt <= len_cnt - 7'd1;
                    if (len_cnt == 7'd1) channel_on <= 1'b0;
                end
                if (env_tick && (env_period_nxt != 3'd0)) begin
                    if (env_timer <= 4'd1) begin
                        env_timer <= {1'b0, env_period_nxt};
                        if (env_dir_nxt && (volume != ENV_MAX))
                            volume <= volume + 4'd1;
                        else if (!env_dir_nxt && (volume != 4'd0))
                            volume <= volume - 4'd1;
                    end else begin
                        env_timer <= env_timer - 4'd1;
                    end
                end
                if (sw_kill) channel_on <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_square_channel_ctrl.sv
// Directed bench for square_channel_ctrl at CLK_DIV=4; sweep vectors run
// only when SQUARE_CTRL_SWEEP_EN is defined.
module tb_square_channel_ctrl;

    localparam int CLK_DIV = 4;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  duty;
    logic [10:0] freq;
    logic [3:0]  volume;
    logic        channel_on;
    logic        phase_reset;
    logic [2:0]  seq_step;

    int checks = 0;
    int errors = 0;

    square_channel_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .duty         (duty),
        .freq         (freq),
        .volume       (volume),
        .channel_on   (channel_on),
        .phase_reset  (phase_reset),
        .seq_step     (seq_step)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the write is taken on the following posedge and
    // its effect is visible when the task returns.
    task automatic write(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge system_clock);
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'd0;
    endtask

    // Returns at the negedge where seq_step has just entered a step in mask,
    // i.e. while that step's tick is pending for the next posedge.
    task automatic wait_mask(input logic [7:0] mask);
        logic [2:0] prev;
        bit         hit;
        prev = seq_step;
        hit  = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge system_clock);
            if (seq_step != prev && mask[seq_step]) hit = 1'b1;
            prev = seq_step;
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL wait_step: observed no step in mask %b, expected one within 80 cycles", mask);
        end
    endtask

    task automatic wait_step(input logic [2:0] s);
        logic [7:0] m;
        m = 8'd1 << s;
        wait_mask(m);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'd0;
        repeat (3) @(negedge system_clock);
        check("rst duty", 16'(duty), 16'h0);
        check("rst freq", 16'(freq), 16'h0);
        check("rst volume", 16'(volume), 16'h0);
        check("rst channel_on", 16'(channel_on), 16'h0);
        check("rst phase_reset", 16'(phase_reset), 16'h0);
        check("rst seq_step", 16'(seq_step), 16'h0);
        reset = 1'b0;

        // Length expiry: len=2, two length ticks later the channel stops.
        wait_step(3'd1);
        write(3'd1, 8'hF0);
        write(3'd0, 8'h3E);
        write(3'd3, 8'hC0);
        check("len trig on", 16'(channel_on), 16'h1);
        check("len trig pulse", 16'(phase_reset), 16'h1);
        check("len trig volume", 16'(volume), 16'hF);
        @(negedge system_clock);
        check("len pulse once", 16'(phase_reset), 16'h0);
        wait_step(3'd4);
        check("len after 1 tick", 16'(channel_on), 16'h1);
        @(negedge system_clock);
        check("len expired", 16'(channel_on), 16'h0);

        // Plain register writes, no trigger.
        write(3'd2, 8'h34);
        write(3'd3, 8'h05);
        check("freq write", 16'(freq), 16'h534);
        check("no trig pulse", 16'(phase_reset), 16'h0);
        write(3'd0, 8'hC0);
        check("duty write", 16'(duty), 16'h3);

        // Envelope up from 0 with period 1, saturating at 15.
        wait_step(3'd0);
        write(3'd1, 8'h09);
        write(3'd3, 8'h80);
        check("env trig volume", 16'(volume), 16'h0);
        check("env trig on", 16'(channel_on), 16'h1);
        check("env trig freq", 16'(freq), 16'h034);
        for (int k = 1; k <= 15; k++) begin
            wait_step(3'd7);
            @(negedge system_clock);
            check($sformatf("env vol %0d", k), 16'(volume), 16'(k));
        end
        wait_step(3'd7);
        @(negedge system_clock);
        check("env saturate", 16'(volume), 16'hF);

        // DAC off stops the channel and blocks re-trigger.
        write(3'd1, 8'h00);
        check("dac off", 16'(channel_on), 16'h0);
        write(3'd3, 8'h80);
        check("dac off trig on", 16'(channel_on), 16'h0);
        check("dac off trig vol", 16'(volume), 16'h0);
        check("dac off trig pulse", 16'(phase_reset), 16'h1);

        // Back-to-back triggers: one pulse cycle per trigger write.
        write(3'd1, 8'hF0);
        write(3'd3, 8'h80);
        check("b2b pulse 1", 16'(phase_reset), 16'h1);
        check("b2b on", 16'(channel_on), 16'h1);
        write(3'd3, 8'h80);
        check("b2b pulse 2", 16'(phase_reset), 16'h1);
        @(negedge system_clock);
        check("b2b pulse end", 16'(phase_reset), 16'h0);

        // Drain length to 0, then trigger in the same cycle as a length tick.
        wait_step(3'd1);
        write(3'd0, 8'h3F);
        write(3'd3, 8'h40);
        wait_step(3'd2);
        @(negedge system_clock);
        check("len1 expired", 16'(channel_on), 16'h0);
        wait_step(3'd4);
        write(3'd3, 8'hC0);
        check("len0 trig on", 16'(channel_on), 16'h1);
        for (int i = 0; i < 63; i++) wait_mask(8'b0101_0101);
        @(negedge system_clock);
        check("len64 after 63", 16'(channel_on), 16'h1);
        wait_mask(8'b0101_0101);
        @(negedge system_clock);
        check("len64 after 64", 16'(channel_on), 16'h0);

        // NRx1 write coinciding with a length tick loads without decrement.
        write(3'd3, 8'hC0);
        check("nrx1 tick trig", 16'(channel_on), 16'h1);
        wait_mask(8'b0101_0101);
        write(3'd0, 8'h3E);
        wait_mask(8'b0101_0101);
        @(negedge system_clock);
        check("nrx1 tick len1", 16'(channel_on), 16'h1);
        wait_mask(8'b0101_0101);
        @(negedge system_clock);
        check("nrx1 tick len0", 16'(channel_on), 16'h0);

`ifdef SQUARE_CTRL_SWEEP_EN
        // 0x700 + (0x700 >> 1) = 0xA80 overflows on the trigger check.
        write(3'd2, 8'h00);
        write(3'd3, 8'h07);
        write(3'd4, 8'h11);
        write(3'd3, 8'h87);
        check("sweep ovf off", 16'(channel_on), 16'h0);
        check("sweep ovf pulse", 16'(phase_reset), 16'h1);
        // 0x100 -> 0x180 on the first sweep tick.
        write(3'd3, 8'h81);
        check("sweep trig on", 16'(channel_on), 16'h1);
        check("sweep trig freq", 16'(freq), 16'h100);
        wait_mask(8'b0100_0100);
        @(negedge system_clock);
        check("sweep step freq", 16'(freq), 16'h180);
        check("sweep step on", 16'(channel_on), 16'h1);
`else
        write(3'd4, 8'hFF);
        check("nrx0 ignored freq", 16'(freq), 16'h034);
        check("nrx0 ignored on", 16'(channel_on), 16'h0);
`endif

        // Asynchronous reset at divider=2 while playing.
        write(3'd0, 8'h80);
        write(3'd1, 8'hF0);
        write(3'd3, 8'h85);
        check("pre-rst on", 16'(channel_on), 16'h1);
        check("pre-rst duty", 16'(duty), 16'h2);
        wait_step(3'd1);
        @(negedge system_clock);
        @(negedge system_clock);
        #2 reset = 1'b1;
        #1;
        check("async rst on", 16'(channel_on), 16'h0);
        check("async rst volume", 16'(volume), 16'h0);
        check("async rst freq", 16'(freq), 16'h0);
        check("async rst duty", 16'(duty), 16'h0);
        check("async rst step", 16'(seq_step), 16'h0);
        @(negedge system_clock);
        reset = 1'b0;
        check("post-rst step", 16'(seq_step), 16'h0);
        repeat (CLK_DIV) @(negedge system_clock);
        check("post-rst step 1", 16'(seq_step), 16'h1);
        check("post-rst on", 16'(channel_on), 16'h0);
        check("post-rst pulse", 16'(phase_reset), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_channel_ctrl.md
Name: square_channel_ctrl

Overview:
Control/sequencing block for one GB-style square-wave channel. It owns the frame sequencer, the NRx1–NRx4 register file, the length counter, the volume envelope and trigger handling. It drives the square datapath with duty, frequency, volume, enable and a phase-reset strobe. It sits between the CPU register bus and the square-wave generator/mixer; the datapath contains no timing logic of its own.

Parameters:
CLK_DIV, 8192, system_clock cycles per frame-sequencer step (512 Hz at 4.194304 MHz); legal values are 2 or greater.

Ports:
system_clock  in  1  single clock for all logic
reset  in  1  asynchronous, active-high; all state cleared
wr_en  in  1  one-cycle register write strobe
wr_addr  in  3  0=NRx1, 1=NRx2, 2=NRx3, 3=NRx4, 4=NRx0 (sweep); 5–7 ignored
wr_data  in  8  write data
duty  out  2  duty select for datapath
freq  out  11  frequency/period value for datapath
volume  out  4  current envelope volume
channel_on  out  1  channel active (NR52 status bit); datapath outputs silence when 0
phase_reset  out  1  one-cycle pulse: restart duty phase and period timer
seq_step  out  3  current frame-sequencer step (debug/status)

Behaviour:
- Reset values: all outputs 0, seq_step=0, divider=0, length counter=0, all register fields 0.
- Divider: counts 0..CLK_DIV-1. On wrap, seq_step increments mod 8, and the events for the new step fire the same cycle as internal single-cycle pulses.
  - length_tick on steps 0,2,4,6
  - sweep_tick on steps 2,6
  - env_tick on step 7
- NRx1 write: duty=d[7:6]; len_cnt = 64 - d[5:0] (7-bit, range 1..64).
- NRx2 write: env_init=d[7:4], env_dir=d[3] (1=up), env_period=d[2:0]. If d[7:3]==0 (DAC off), clear channel_on next cycle.
- NRx3 write: freq[7:0]=d.
- NRx4 write: freq[10:8]=d[2:0], len_en=d[6]. If d[7]=1, trigger.
- Trigger, registered with 1-cycle latency:
  - channel_on=1 only if DAC on.
  - If len_cnt==0, len_cnt=64.
  - volume=env_init.
  - env_timer=env_period, with 0 loaded as 8.
  - phase_reset pulses exactly one cycle.
- Length: on length_tick, if len_en and len_cnt!=0, decrement. A transition to 0 clears channel_on the same cycle. The counter stays at 0 with no wrap.
- Envelope: on env_tick, if env_period!=0, decrement env_timer. When env_timer reaches 0, reload it and step volume ±1. Volume saturates at 0/15 and stops; it never wraps. env_period==0 freezes the envelope.
- Simultaneous events in one cycle:
  - Register write is applied before any tick.
  - Trigger beats length decrement: the reload happens and no decrement occurs that cycle.
  - NRx1 write beats length_tick: the counter loads and does not decrement.
- Writes to NRx1–NRx4 while channel_on=0 are accepted.
- Reset mid-operation clears everything immediately; no pending trigger survives.
- Back-to-back triggers give one phase_reset pulse per trigger write.

Optional Feature:
SQUARE_CTRL_SWEEP_EN
- Defined: addr 4 (NRx0) sets sw_period=d[6:4], sw_neg=d[3], sw_shift=d[2:0].
- On trigger:
  - shadow=freq.
  - sw_timer=sw_period, with 0 loaded as 8.
  - If sw_shift!=0, do an immediate overflow check.
- On sweep_tick, decrement sw_timer. When it reaches 0 and sw_period!=0:
  - Compute new = shadow ± (shadow >> sw_shift), using 12-bit arithmetic.
  - If new>2047, clear channel_on.
  - Otherwise, if sw_shift!=0, load shadow and freq with new, then run a second overflow check.
- Undefined: addr 4 is ignored, no sweep logic exists, and freq changes only via NRx3/NRx4 writes.

Decomposition:
- Package square_ctrl_pkg:
  - register address enum (NRX0..NRX4)
  - LEN_MAX=64
  - step masks LEN_STEPS=8'b0101_0101, SWEEP_STEPS=8'b0100_0100, ENV_STEPS=8'b1000_0000
  - ENV_MAX=15
- Sub-module apu_frame_sequencer: divider plus 3-bit step counter; emits length_tick, sweep_tick, env_tick and seq_step. It is shareable across channels.

Test Plan (CLK_DIV=4):
- Reset mid-count: assert reset asynchronously at divider=2 → all outputs 0 in the same cycle; seq_step=0 after release.
- Length expiry: NRx2=0xF0, NRx1=0x3E (len=2), NRx4=0xC0 → channel_on=1 and phase_reset pulses once; channel_on drops at the second length_tick.
- Envelope up: NRx2=0x09 (vol 0, up, period 1), trigger → volume becomes 1,2,… on each env_tick (every 32 cycles) and holds at 15.
- DAC off: channel playing, write NRx2=0x00 → channel_on=0 next cycle; a subsequent trigger leaves channel_on=0.
- Trigger with len_cnt==0 and length_tick in the same cycle → len_cnt=64, no decrement.
- Sweep (macro on): freq=0x700, NRx0=0x11 (period 1, add, shift 1), trigger → overflow check gives 0xA80 > 2047, so channel_on=0.
